// File: rtl/uart_tx_fifo_if.sv
// Byte-producer handshake between user logic and the UART transmit engine.
// The producer (master) drives tx_data/push_tx; the engine (slave) reports
// FIFO status and activity.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH_LOG2 = 4
);
    logic [7:0]               tx_data;
    logic                     push_tx;
    logic                     tx_full;
    logic                     tx_empty;
    logic [FIFO_DEPTH_LOG2:0] tx_level;
    logic                     tx_busy;

    modport master (
        output tx_data,
        output push_tx,
        input  tx_full,
        input  tx_empty,
        input  tx_level,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  push_tx,
        output tx_full,
        output tx_empty,
        output tx_level,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmit engine: a 2**FIFO_DEPTH_LOG2 byte FIFO feeding an 8N1
// serialiser on tx_line_o. Bit period is CLK_FREQ/BAUDS clocks (truncated).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, waiting for the FIFO to become non-empty
// START  | start bit (low) held for DIV clocks
// DATA   | eight data bits, LSB first, DIV clocks each
// STOP   | stop bit (high) for DIV clocks; chains straight into START
module uart_tx_fifo #(
    parameter int CLK_FREQ        = 27000000,
    parameter int BAUDS           = 115200,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_tx_fifo_if.slave bus,
    output logic          tx_line_o
);
    localparam int DIV   = CLK_FREQ / BAUDS;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             line_q, line_d;
    logic             baud_tick;

    // Status flags come straight from the registered occupancy.
    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);
    assign push_ok = bus.push_tx && !full;

    // Pointer and occupancy bookkeeping; the FSM only pops when non-empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // FIFO pointer/level registers; reset discards anything queued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            mem_q[wr_ptr_q] <= bus.tx_data;
        end
    end

    assign baud_tick = (cnt_q == CNT_LAST);

    // FSM state register together with its datapath and the registered line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            line_q  <= line_d;
        end
    end

    // Next-state logic: bit timing and FIFO pops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    cnt_d = '0;
                    // Chain the next queued byte with no idle gap.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: the line value for the state being entered, registered above.
    always_comb begin
        line_d = 1'b1;
        case (state_d)
            S_START: line_d = 1'b0;
            S_DATA:  line_d = shift_d[bit_d];
            default: line_d = 1'b1;
        endcase
    end

    assign bus.tx_full  = full;
    assign bus.tx_empty = empty;
    assign bus.tx_level = level_q;
    assign bus.tx_busy  = (state_q != S_IDLE) || !empty;
    assign tx_line_o    = line_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a fast instance (DIV=4) for functional cases and a
// default-parameter instance (DIV=234) for bit-period timing.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int LOG2  = 4;
    localparam int DIV_S = 4;
    localparam int DIV_D = 234;

    logic clk = 1'b0;
    logic rst_s;
    logic rst_d;
    logic line_s;
    logic line_d;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rx_q [$];
    logic [7:0] rx_b;
    int         low_cnt;

    uart_tx_fifo_if #(.FIFO_DEPTH_LOG2(LOG2)) if_s ();
    uart_tx_fifo_if #(.FIFO_DEPTH_LOG2(LOG2)) if_d ();

    uart_tx_fifo #(
        .CLK_FREQ        (1000000),
        .BAUDS           (250000),
        .FIFO_DEPTH_LOG2 (LOG2)
    ) dut_s (
        .clk_i     (clk),
        .rst_i     (rst_s),
        .bus       (if_s),
        .tx_line_o (line_s)
    );

    uart_tx_fifo dut_d (
        .clk_i     (clk),
        .rst_i     (rst_d),
        .bus       (if_d),
        .tx_line_o (line_d)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called with the first start-bit cycle visible; checks every cycle of the frame.
    task automatic expect_frame(input bit sel, input int div, input logic [7:0] b, input string tag);
        int         bad = 0;
        logic [7:0] sh  = b;
        logic [7:0] got = '0;
        logic       exp;
        logic       ln;
        for (int c = 0; c < 10 * div; c++) begin
            if (c < div) exp = 1'b0;
            else if (c < 9 * div) exp = sh[0];
            else exp = 1'b1;
            ln = sel ? line_d : line_s;
            if (ln !== exp) bad++;
            if (c >= div && c < 9 * div) begin
                if ((c % div) == div / 2) got = {ln, got[7:1]};
                if ((c % div) == div - 1) sh = sh >> 1;
            end
            tick();
        end
        chk({tag, "_bad_cycles"}, 32'(bad), 32'd0);
        chk({tag, "_byte"}, 32'(got), 32'(b));
    endtask

    task automatic wait_start(input int budget, input string tag, output bit ok);
        int n = 0;
        while (line_s !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        ok = (line_s === 1'b0);
        chk({tag, "_start_seen"}, 32'(ok), 32'd1);
    endtask

    // Mid-bit sampling receiver on the fast instance; returns aligned to the next frame slot.
    task automatic rx_byte(input string tag, output logic [7:0] b);
        bit ok;
        b = '0;
        wait_start(120, tag, ok);
        if (ok) begin
            repeat (DIV_S / 2) tick();
            for (int k = 0; k < 8; k++) begin
                repeat (DIV_S) tick();
                b = {line_s, b[7:1]};
            end
            repeat (DIV_S) tick();
            chk({tag, "_stop"}, 32'(line_s), 32'd1);
            repeat (DIV_S / 2) tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with push held high
        rst_s = 1'b1;
        rst_d = 1'b1;
        if_s.push_tx = 1'b1;
        if_s.tx_data = 8'hFF;
        if_d.push_tx = 1'b0;
        if_d.tx_data = 8'h00;
        repeat (3) tick();
        chk("t1_line",  32'(line_s),        32'd1);
        chk("t1_empty", 32'(if_s.tx_empty), 32'd1);
        chk("t1_full",  32'(if_s.tx_full),  32'd0);
        chk("t1_level", 32'(if_s.tx_level), 32'd0);
        chk("t1_busy",  32'(if_s.tx_busy),  32'd0);
        rst_s = 1'b0;
        if_s.push_tx = 1'b0;
        repeat (5) tick();
        chk("t1_idle_line",  32'(line_s),        32'd1);
        chk("t1_idle_empty", 32'(if_s.tx_empty), 32'd1);

        // 2: single byte, latency and full frame
        if_s.tx_data = 8'h55;
        if_s.push_tx = 1'b1;
        tick();
        if_s.push_tx = 1'b0;
        if_s.tx_data = 8'hFF;
        chk("t2_line_e1",  32'(line_s),        32'd1);
        chk("t2_level_e1", 32'(if_s.tx_level), 32'd1);
        chk("t2_busy_e1",  32'(if_s.tx_busy),  32'd1);
        tick();
        chk("t2_start_e2", 32'(line_s),        32'd0);
        chk("t2_level_e2", 32'(if_s.tx_level), 32'd0);
        expect_frame(1'b0, DIV_S, 8'h55, "t2");
        chk("t2_busy_end", 32'(if_s.tx_busy), 32'd0);
        chk("t2_line_end", 32'(line_s),       32'd1);

        // 3: two back-to-back frames; push and pop in the same cycle
        repeat (3) tick();
        if_s.tx_data = 8'hA5;
        if_s.push_tx = 1'b1;
        tick();
        if_s.tx_data = 8'h3C;
        tick();
        if_s.push_tx = 1'b0;
        chk("t3_level_pushpop", 32'(if_s.tx_level), 32'd1);
        chk("t3_start",         32'(line_s),        32'd0);
        expect_frame(1'b0, DIV_S, 8'hA5, "t3_f0");
        expect_frame(1'b0, DIV_S, 8'h3C, "t3_f1");
        chk("t3_busy_end", 32'(if_s.tx_busy), 32'd0);

        // 4: overfill the FIFO; the 18th byte must be dropped
        repeat (3) tick();
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    if_s.tx_data = 8'(i);
                    if_s.push_tx = 1'b1;
                    tick();
                    if (i == 15) chk("t4_full_16th", 32'(if_s.tx_full), 32'd0);
                    if (i == 16) begin
                        chk("t4_full_17th",  32'(if_s.tx_full),  32'd1);
                        chk("t4_level_17th", 32'(if_s.tx_level), 32'd16);
                    end
                end
                if_s.push_tx = 1'b0;
                chk("t4_level_drop", 32'(if_s.tx_level), 32'd16);
                chk("t4_full_drop",  32'(if_s.tx_full),  32'd1);
            end
            begin
                for (int k = 0; k < 17; k++) begin
                    rx_byte("t4_rx", rx_b);
                    rx_q.push_back(rx_b);
                end
            end
        join
        chk("t4_count", 32'(rx_q.size()), 32'd17);
        for (int k = 0; k < rx_q.size(); k++) begin
            chk($sformatf("t4_byte%0d", k), 32'(rx_q[k]), 32'(k));
        end
        low_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (line_s !== 1'b1) low_cnt++;
            tick();
        end
        chk("t4_no_extra_frame", 32'(low_cnt),       32'd0);
        chk("t4_empty_end",      32'(if_s.tx_empty), 32'd1);

        // 5: reset during data bit 3 with three bytes queued
        if_s.tx_data = 8'hC3;
        if_s.push_tx = 1'b1;
        tick();
        if_s.tx_data = 8'h11;
        tick();
        if_s.tx_data = 8'h22;
        tick();
        if_s.tx_data = 8'h33;
        tick();
        if_s.push_tx = 1'b0;
        chk("t5_level_queued", 32'(if_s.tx_level), 32'd3);
        repeat (15) tick();
        chk("t5_bit3", 32'(line_s), 32'd0);
        rst_s = 1'b1;
        tick();
        chk("t5_line_rst",  32'(line_s),        32'd1);
        chk("t5_level_rst", 32'(if_s.tx_level), 32'd0);
        chk("t5_empty_rst", 32'(if_s.tx_empty), 32'd1);
        chk("t5_busy_rst",  32'(if_s.tx_busy),  32'd0);
        rst_s = 1'b0;
        low_cnt = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (line_s !== 1'b1) low_cnt++;
        end
        chk("t5_no_frames", 32'(low_cnt),      32'd0);
        chk("t5_busy_after", 32'(if_s.tx_busy), 32'd0);

        // 6: default parameters, bit period of 234 clocks
        rst_d = 1'b0;
        tick();
        if_d.tx_data = 8'h00;
        if_d.push_tx = 1'b1;
        tick();
        if_d.push_tx = 1'b0;
        chk("t6_line_e1", 32'(line_d), 32'd1);
        tick();
        chk("t6_start_e2", 32'(line_d), 32'd0);
        expect_frame(1'b1, DIV_D, 8'h00, "t6");
        chk("t6_busy_end", 32'(if_d.tx_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
